// File: rtl/core_pkg.sv
// Shared constants and types for the fetch side of the pipelined RISC-V core.
package core_pkg;

  // Default datapath / PC width.
  localparam int CORE_N = 32;

  // PC loaded on reset and the bubble instruction (ADDI x0,x0,0).
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CORE_NOP      = 32'h0000_0013;

  // Width of the debug event counters.
  localparam int CORE_CNT_W = 16;

  // Fetch FSM: one boot cycle after reset, then normal running.
  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Bus between the fetch stage and its neighbours (hazard unit, PC mux, imem, ID).
interface fetch_pc_stage_if
  import core_pkg::*;
#(
  parameter int N     = CORE_N,
  parameter int CNT_W = CORE_CNT_W
);
  logic             stall;
  logic             branch_taken;
  logic [N-1:0]     next_pc_sel;
  logic [N-1:0]     instr_in;
  logic [N-1:0]     pc;
  logic [N-1:0]     ifid_pc;
  logic [N-1:0]     ifid_instr;
  logic             ifid_valid;
  logic             flush_idex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // The fetch stage itself.
  modport slave (
    input  stall, branch_taken, next_pc_sel, instr_in,
    output pc, ifid_pc, ifid_instr, ifid_valid, flush_idex, stall_cnt, flush_cnt
  );

  // Whoever drives the fetch stage (rest of the core, or a bench).
  modport master (
    output stall, branch_taken, next_pc_sel, instr_in,
    input  pc, ifid_pc, ifid_instr, ifid_valid, flush_idex, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/en_reg.sv
// Generic N-bit register with load enable and synchronous active-low reset.
module en_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Reset wins; otherwise load when enabled, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Unsigned event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  // Clear on reset; count up on i_inc until the maximum value is reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {W{1'b1}})) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: program counter, IF/ID pipeline register, stall/redirect
// handling, post-reset boot cycle and debug event counters.
module fetch_pc_stage
  import core_pkg::*;
#(
  parameter int           N        = CORE_N,
  parameter logic [N-1:0] RESET_PC = N'(CORE_RESET_PC),
  parameter logic [N-1:0] NOP      = N'(CORE_NOP),
  parameter int           CNT_W    = CORE_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_stage_if.slave bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [N-1:0] r_pc;
  logic [N-1:0] r_ifid_pc;
  logic [N-1:0] r_ifid_instr;
  logic         r_ifid_valid;

  logic         w_pc_en;
  logic         w_ifid_en;
  logic [N-1:0] w_ifid_instr_d;
  logic         w_ifid_valid_d;
  logic         w_stall_inc;
  logic         w_flush_inc;

  // FSM state register; reset always returns to the boot cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leave boot on the first non-stalled edge; S_RUN is only left via reset.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_BOOT) && !bus.stall) begin
      w_state_next = S_RUN;
    end
  end

  // Per-edge control: redirect beats stall; in boot no branch can be in flight.
  always_comb begin
    w_pc_en        = 1'b0;
    w_ifid_en      = 1'b0;
    w_ifid_instr_d = bus.instr_in;
    w_ifid_valid_d = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (!bus.stall) begin
          w_pc_en        = 1'b1;
          w_ifid_en      = 1'b1;
          w_ifid_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.branch_taken) begin
          w_pc_en        = 1'b1;
          w_ifid_en      = 1'b1;
          w_ifid_instr_d = NOP;
          w_ifid_valid_d = 1'b0;
          w_flush_inc    = 1'b1;
        end else if (bus.stall) begin
          w_stall_inc    = 1'b1;
        end else begin
          w_pc_en        = 1'b1;
          w_ifid_en      = 1'b1;
          w_ifid_valid_d = 1'b1;
        end
      end
      default: begin
        w_pc_en = 1'b0;
      end
    endcase
  end

  en_reg #(.W(N), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst(rst), .i_en(w_pc_en), .i_d(bus.next_pc_sel), .o_q(r_pc)
  );

  // IF/ID always captures the PC that was being fetched, bubble or not.
  en_reg #(.W(N), .RST_VAL('0)) u_ifid_pc_reg (
    .clk(clk), .rst(rst), .i_en(w_ifid_en), .i_d(r_pc), .o_q(r_ifid_pc)
  );

  en_reg #(.W(N), .RST_VAL(NOP)) u_ifid_instr_reg (
    .clk(clk), .rst(rst), .i_en(w_ifid_en), .i_d(w_ifid_instr_d), .o_q(r_ifid_instr)
  );

  en_reg #(.W(1), .RST_VAL(1'b0)) u_ifid_valid_reg (
    .clk(clk), .rst(rst), .i_en(w_ifid_en), .i_d(w_ifid_valid_d), .o_q(r_ifid_valid)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .i_inc(w_stall_inc), .o_cnt(bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .i_inc(w_flush_inc), .o_cnt(bus.flush_cnt)
  );

  assign bus.pc         = r_pc;
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_valid = r_ifid_valid;
  // ID/EX kill follows the resolved branch directly, independent of FSM state.
  assign bus.flush_idex = bus.branch_taken;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed test-plan steps followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_fetch_pc_stage;

  localparam int          N     = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam int          SAT   = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_pc_stage_if #(.N(N), .CNT_W(CW)) bus ();

  fetch_pc_stage #(.N(N), .RESET_PC(RPC), .NOP(NOP_W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // Reference model state.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_valid;
  logic        m_boot = 1'b1;
  int          m_stall_cnt = 0;
  int          m_flush_cnt = 0;
  logic [31:0] key = 32'h0;   // imem returns pc ^ key

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %08h expected %08h", tag, step_no, obs, exp_v);
    end
  endtask

  // One clock: drive at negedge, predict, check 1 time unit after posedge.
  task automatic step(input bit r, input bit st, input bit bt, input logic [31:0] nps);
    @(negedge clk);
    rst              = r;
    bus.stall        = st;
    bus.branch_taken = bt;
    bus.next_pc_sel  = nps;
    bus.instr_in     = bus.pc ^ key;
    #1;
    check("flush_idex", {31'b0, bus.flush_idex}, {31'b0, bt});
    if (!r) begin
      m_pc = RPC; m_ifid_pc = 32'h0; m_ifid_instr = NOP_W; m_valid = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_boot = 1'b1;
    end else if (m_boot) begin
      if (!st) begin
        m_ifid_pc = m_pc; m_ifid_instr = m_pc ^ key; m_valid = 1'b1;
        m_pc = nps; m_boot = 1'b0;
      end
    end else if (bt) begin
      m_ifid_pc = m_pc; m_ifid_instr = NOP_W; m_valid = 1'b0;
      m_pc = nps;
      m_flush_cnt = (m_flush_cnt + 1 > SAT) ? SAT : m_flush_cnt + 1;
    end else if (st) begin
      m_stall_cnt = (m_stall_cnt + 1 > SAT) ? SAT : m_stall_cnt + 1;
    end else begin
      m_ifid_pc = m_pc; m_ifid_instr = m_pc ^ key; m_valid = 1'b1;
      m_pc = nps;
    end
    @(posedge clk);
    #1;
    step_no++;
    check("pc",         bus.pc,                   m_pc);
    check("ifid_pc",    bus.ifid_pc,              m_ifid_pc);
    check("ifid_instr", bus.ifid_instr,           m_ifid_instr);
    check("ifid_valid", {31'b0, bus.ifid_valid},  {31'b0, m_valid});
    check("stall_cnt",  32'(bus.stall_cnt),       32'(m_stall_cnt));
    check("flush_cnt",  32'(bus.flush_cnt),       32'(m_flush_cnt));
    $display("step %0d rst=%0b stall=%0b bt=%0b nps=%08h -> pc=%08h ifid_pc=%08h instr=%08h v=%0b sc=%0d fc=%0d",
             step_no, r, st, bt, nps, bus.pc, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid,
             bus.stall_cnt, bus.flush_cnt);
  endtask

  initial begin
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.next_pc_sel  = 32'h0;
    bus.instr_in     = 32'h0;

    // Reset for two cycles, then run straight-line.
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(1, 0, 0, m_pc + 4);          // boot edge: pc 0 -> 4, IF/ID valid
    step(1, 0, 0, m_pc + 4);          // pc 8
    // Stall three cycles at pc=8, then release.
    step(1, 1, 0, m_pc + 4);
    step(1, 1, 0, m_pc + 4);
    step(1, 1, 0, m_pc + 4);
    step(1, 0, 0, m_pc + 4);          // pc 12
    step(1, 0, 0, m_pc + 4);          // pc 16
    // Redirect at pc=16.
    step(1, 0, 1, 32'h0000_0100);
    step(1, 0, 0, m_pc + 4);          // ifid_pc = 0x100, valid
    // Simultaneous stall and redirect: redirect wins.
    step(1, 1, 1, 32'h0000_0200);
    step(1, 0, 0, m_pc + 4);
    // Get to 0x40, stall there, then reset in the middle of the stall.
    step(1, 0, 1, 32'h0000_0040);
    step(1, 1, 0, m_pc + 4);
    step(0, 1, 0, m_pc + 4);
    // Boot cycle: stall holds it, branch_taken is ignored (no flush count).
    step(1, 1, 0, m_pc + 4);
    step(1, 0, 1, 32'h0000_0999);
    step(1, 0, 0, m_pc + 4);
    // Saturation: 20 stalled cycles with a 4-bit counter.
    for (int i = 0; i < 20; i++) step(1, 1, 0, m_pc + 4);
    // Same for the flush counter.
    for (int i = 0; i < 18; i++) step(1, 0, 1, 32'h0000_0300 + 32'(i * 4));

    // Random traffic with a scrambled imem.
    key = $urandom;
    step(0, 0, 0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      bit          r, st, bt;
      logic [31:0] nps;
      r   = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 3) == 0);
      bt  = ($urandom_range(0, 5) == 0);
      if (bt) nps = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      else    nps = m_pc + 4;
      step(r, st, bt, nps);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
